// File: rtl/megarom_bank_mapper.sv
// Megarom bank mapper: holds the four live bank registers, decodes MSX slot
// cycles in 4000h-BFFFh into RAM requests, and returns read data to the bus
// while holding the Z80 with WAIT_n until the RAM answers.
module megarom_bank_mapper #(
   parameter int RAM_ADDR_WIDTH = 24,
   parameter int BANK_WIDTH     = 8
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      BUS_RESET_n,
   input  logic                      SLTSL_n,
   input  logic                      MERQ_n,
   input  logic                      RD_n,
   input  logic                      WR_n,
   input  logic [15:0]               ADDR,
   input  logic [7:0]                DIN,
   output logic [7:0]                DOUT,
   output logic                      BUSDIR_n,
   output logic                      WAIT_n,
   input  logic [15:0]               BANK_REG_ADDR0,
   input  logic [15:0]               BANK_REG_ADDR1,
   input  logic [15:0]               BANK_REG_ADDR2,
   input  logic [15:0]               BANK_REG_ADDR3,
   input  logic [15:0]               BANK_REG_ADDR_MASK,
   input  logic [7:0]                BANK_REG_MASK,
   input  logic [BANK_WIDTH-1:0]     BANK_REG_INIT0,
   input  logic [BANK_WIDTH-1:0]     BANK_REG_INIT1,
   input  logic [BANK_WIDTH-1:0]     BANK_REG_INIT2,
   input  logic [BANK_WIDTH-1:0]     BANK_REG_INIT3,
   input  logic                      WRITE_PROTECT,
   input  logic                      IS_16K_BANK,
   input  logic                      CS1_MASK,
   input  logic                      CS2_MASK,
   input  logic [RAM_ADDR_WIDTH-1:0] MEMORY_TOP_ADDR,
   output logic                      RAM_REQ,
   output logic                      RAM_WE,
   output logic [RAM_ADDR_WIDTH-1:0] RAM_ADDR,
   output logic [7:0]                RAM_WDATA,
   input  logic                      RAM_ACK,
   input  logic [7:0]                RAM_RDATA
);

   localparam int OFF_W = BANK_WIDTH + 14;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t                    state, state_d;
   logic                      rst;
   logic                      rd_n, wr_n, prev_rd_n, prev_wr_n, det_rd, det_wr;
   logic [15:0]               bank_reg_addr [4];
   logic [BANK_WIDTH-1:0]     bank [4];
   logic [3:0]                bank_hit;
   logic                      any_hit;
   logic [BANK_WIDTH-1:0]     bank_wdata;
   logic                      cs;
   logic [1:0]                idx;
   logic [OFF_W-1:0]          off_wide;
   logic [RAM_ADDR_WIDTH-1:0] offset, ram_addr_calc;
   logic                      drive_q, drive_d;
   logic                      req_d, we_d, wait_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_d;
   logic [7:0]                wdata_d, dout_d;

   // The MSX bus reset restarts the mapper exactly like the system reset.
   assign rst  = RESET | ~BUS_RESET_n;
   assign rd_n = SLTSL_n | MERQ_n | RD_n;
   assign wr_n = SLTSL_n | MERQ_n | WR_n;
   assign det_rd = prev_rd_n & ~rd_n;
   assign det_wr = prev_wr_n & ~wr_n;

   assign bank_reg_addr[0] = BANK_REG_ADDR0;
   assign bank_reg_addr[1] = BANK_REG_ADDR1;
   assign bank_reg_addr[2] = BANK_REG_ADDR2;
   assign bank_reg_addr[3] = BANK_REG_ADDR3;

   // Bus strobe history for falling-edge detection.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         prev_rd_n <= 1'b1;
         prev_wr_n <= 1'b1;
      end else begin
         prev_rd_n <= rd_n;
         prev_wr_n <= wr_n;
      end
   end

   // Bank-register address compare; several registers may match one write.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      bank_hit = '0;
      for (int i = 0; i < 4; i++)
         bank_hit[i] = ((ADDR ^ bank_reg_addr[i]) & ~BANK_REG_ADDR_MASK) == 16'h0000;
   end
   assign any_hit = |bank_hit;

   // Fit the masked 8-bit bus data to the bank register width.
   if (BANK_WIDTH == 8) begin : g_bw_eq
      assign bank_wdata = DIN & ~BANK_REG_MASK;
   end else if (BANK_WIDTH > 8) begin : g_bw_gt
      assign bank_wdata = {{(BANK_WIDTH-8){1'b0}}, DIN & ~BANK_REG_MASK};
   end else begin : g_bw_lt
      logic [7:0] masked;
      assign masked     = DIN & ~BANK_REG_MASK;
      assign bank_wdata = masked[BANK_WIDTH-1:0];
   end

   // Live bank registers: reload init values on reset, update on matching writes.
   always_ff @(posedge CLK) begin
      // NOTE: the bank file is reset, but to configuration inputs rather than constants,
      // so a bus reset restores the cartridge's power-on page layout.
      if (rst) begin
         bank[0] <= BANK_REG_INIT0;
         bank[1] <= BANK_REG_INIT1;
         bank[2] <= BANK_REG_INIT2;
         bank[3] <= BANK_REG_INIT3;
      end else if (det_wr) begin
         for (int i = 0; i < 4; i++)
            if (bank_hit[i]) bank[i] <= bank_wdata;
      end
   end

   // Page decode: chip selects, bank index and the ROM image offset.
   assign cs  = ((ADDR[15:14] == 2'b01) && !CS1_MASK) || ((ADDR[15:14] == 2'b10) && !CS2_MASK);
   assign idx = IS_16K_BANK ? {1'b0, ADDR[15]} : {ADDR[15], ADDR[13]};
   assign off_wide = IS_16K_BANK ? {bank[idx], ADDR[13:0]} : {1'b0, bank[idx], ADDR[12:0]};

   if (OFF_W == RAM_ADDR_WIDTH) begin : g_off_eq
      assign offset = off_wide;
   end else if (OFF_W < RAM_ADDR_WIDTH) begin : g_off_ext
      assign offset = {{(RAM_ADDR_WIDTH-OFF_W){1'b0}}, off_wide};
   end else begin : g_off_trunc
      assign offset = off_wide[RAM_ADDR_WIDTH-1:0];
   end

   // Wraps modulo 2^RAM_ADDR_WIDTH by construction.
   assign ram_addr_calc = MEMORY_TOP_ADDR + offset;

   // Next-state and next-output logic for the bus/RAM handshake.
   always_comb begin
      state_d = state;
      req_d   = RAM_REQ;
      we_d    = RAM_WE;
      addr_d  = RAM_ADDR;
      wdata_d = RAM_WDATA;
      dout_d  = DOUT;
      drive_d = drive_q;
      wait_d  = WAIT_n;
      case (state)
         IDLE: begin
            if (det_rd && cs) begin
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = ram_addr_calc;
               wait_d  = 1'b0;
            end else if (det_wr && cs && !WRITE_PROTECT && !any_hit) begin
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = ram_addr_calc;
               wdata_d = DIN;
               wait_d  = 1'b0;
            end
         end
         REQ: begin
            if (RAM_ACK) begin
               state_d = DONE;
               req_d   = 1'b0;
               wait_d  = 1'b1;
               // A read whose strobe was already released completes silently.
               if (!RAM_WE && !rd_n) begin
                  dout_d  = RAM_RDATA;
                  drive_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (rd_n && wr_n) begin
               state_d = IDLE;
               drive_d = 1'b0;
               dout_d  = 8'h00;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered bus/RAM outputs.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state     <= IDLE;
         RAM_REQ   <= 1'b0;
         RAM_WE    <= 1'b0;
         RAM_ADDR  <= '0;
         RAM_WDATA <= 8'h00;
         DOUT      <= 8'h00;
         drive_q   <= 1'b0;
         WAIT_n    <= 1'b1;
      end else begin
         state     <= state_d;
         RAM_REQ   <= req_d;
         RAM_WE    <= we_d;
         RAM_ADDR  <= addr_d;
         RAM_WDATA <= wdata_d;
         DOUT      <= dout_d;
         drive_q   <= drive_d;
         WAIT_n    <= wait_d;
      end
   end

   // Gating with the live strobe keeps the bus driver off the moment RD_n rises.
   assign BUSDIR_n = ~(drive_q & ~rd_n);

endmodule

// File: tb/tb_megarom_bank_mapper.sv
// Directed bench for megarom_bank_mapper: a transaction-level model of the
// bank registers and address map sets expected outputs, one compare process
// checks them every cycle, and literal addresses pin the model.
module tb_megarom_bank_mapper;

   logic        CLK, RESET, BUS_RESET_n;
   logic        SLTSL_n, MERQ_n, RD_n, WR_n;
   logic [15:0] ADDR;
   logic [7:0]  DIN, DOUT;
   logic        BUSDIR_n, WAIT_n;
   logic [15:0] BANK_REG_ADDR0, BANK_REG_ADDR1, BANK_REG_ADDR2, BANK_REG_ADDR3;
   logic [15:0] BANK_REG_ADDR_MASK;
   logic [7:0]  BANK_REG_MASK;
   logic [7:0]  BANK_REG_INIT0, BANK_REG_INIT1, BANK_REG_INIT2, BANK_REG_INIT3;
   logic        WRITE_PROTECT, IS_16K_BANK, CS1_MASK, CS2_MASK;
   logic [23:0] MEMORY_TOP_ADDR;
   logic        RAM_REQ, RAM_WE, RAM_ACK;
   logic [23:0] RAM_ADDR;
   logic [7:0]  RAM_WDATA, RAM_RDATA;

   megarom_bank_mapper #(.RAM_ADDR_WIDTH(24), .BANK_WIDTH(8)) dut (
      .CLK(CLK), .RESET(RESET), .BUS_RESET_n(BUS_RESET_n),
      .SLTSL_n(SLTSL_n), .MERQ_n(MERQ_n), .RD_n(RD_n), .WR_n(WR_n),
      .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .BUSDIR_n(BUSDIR_n), .WAIT_n(WAIT_n),
      .BANK_REG_ADDR0(BANK_REG_ADDR0), .BANK_REG_ADDR1(BANK_REG_ADDR1),
      .BANK_REG_ADDR2(BANK_REG_ADDR2), .BANK_REG_ADDR3(BANK_REG_ADDR3),
      .BANK_REG_ADDR_MASK(BANK_REG_ADDR_MASK), .BANK_REG_MASK(BANK_REG_MASK),
      .BANK_REG_INIT0(BANK_REG_INIT0), .BANK_REG_INIT1(BANK_REG_INIT1),
      .BANK_REG_INIT2(BANK_REG_INIT2), .BANK_REG_INIT3(BANK_REG_INIT3),
      .WRITE_PROTECT(WRITE_PROTECT), .IS_16K_BANK(IS_16K_BANK),
      .CS1_MASK(CS1_MASK), .CS2_MASK(CS2_MASK), .MEMORY_TOP_ADDR(MEMORY_TOP_ADDR),
      .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
      .RAM_ACK(RAM_ACK), .RAM_RDATA(RAM_RDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Model state: live bank values plus the outputs expected right now.
   logic [7:0]  m_bank [4];
   logic        chk_en = 1'b0;
   logic        exp_req, exp_we, exp_wait_n, exp_busdir_n;
   logic [23:0] exp_addr;
   logic [7:0]  exp_wdata, exp_dout;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic in_window(input logic [15:0] a);
      return (a >= 16'h4000 && a < 16'h8000 && !CS1_MASK) ||
             (a >= 16'h8000 && a < 16'hC000 && !CS2_MASK);
   endfunction

   // ROM image address: page number from the bank, byte within the page from the bus.
   function automatic logic [23:0] model_addr(input logic [15:0] a);
      int unsigned ai, page, idx, off, sum;
      ai   = a;
      page = IS_16K_BANK ? 32'h4000 : 32'h2000;
      idx  = (ai - 32'h4000) / page;
      off  = 32'(m_bank[idx]) * page + ai % page;
      sum  = 32'(MEMORY_TOP_ADDR) + off;
      return 24'(sum % 32'h0100_0000);
   endfunction

   function automatic logic [3:0] model_hits(input logic [15:0] a);
      logic [15:0] ra [4];
      logic [3:0]  h;
      ra[0] = BANK_REG_ADDR0; ra[1] = BANK_REG_ADDR1;
      ra[2] = BANK_REG_ADDR2; ra[3] = BANK_REG_ADDR3;
      h = '0;
      for (int i = 0; i < 4; i++)
         h[i] = ((a ^ ra[i]) & ~BANK_REG_ADDR_MASK) == 16'h0000;
      return h;
   endfunction

   task automatic model_reset();
      m_bank[0] = BANK_REG_INIT0; m_bank[1] = BANK_REG_INIT1;
      m_bank[2] = BANK_REG_INIT2; m_bank[3] = BANK_REG_INIT3;
      exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = 8'h00;
      exp_wait_n = 1'b1; exp_busdir_n = 1'b1; exp_dout = 8'h00;
   endtask

   task automatic release_bus();
      SLTSL_n = 1'b1; MERQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("RAM_REQ", RAM_REQ, exp_req);
         check("WAIT_n", WAIT_n, exp_wait_n);
         check("BUSDIR_n", BUSDIR_n, exp_busdir_n);
         check("DOUT", DOUT, exp_dout);
         if (exp_req) begin
            check("RAM_ADDR", RAM_ADDR, exp_addr);
            check("RAM_WE", RAM_WE, exp_we);
            if (exp_we) check("RAM_WDATA", RAM_WDATA, exp_wdata);
         end
      end
   end

   // Memory read cycle; lit_addr pins the expected RAM address when use_lit is set.
   task automatic bus_read(input logic [15:0] a, input logic [7:0] rdata, input int delay,
                           input logic use_lit, input logic [23:0] lit_addr);
      logic access;
      access  = in_window(a);
      ADDR    = a;
      SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
      step();
      if (access) begin
         exp_req = 1'b1; exp_we = 1'b0; exp_addr = model_addr(a); exp_wait_n = 1'b0;
         if (use_lit) begin
            #3 check("lit_read_addr", RAM_ADDR, lit_addr);
         end
         repeat (delay) step();
         RAM_ACK = 1'b1; RAM_RDATA = rdata;
         step();
         RAM_ACK = 1'b0; RAM_RDATA = 8'h00;
         exp_req = 1'b0; exp_wait_n = 1'b1; exp_dout = rdata; exp_busdir_n = 1'b0;
         step();
         release_bus();
         exp_busdir_n = 1'b1;
         step();
         exp_dout = 8'h00;
      end else begin
         step();
         release_bus();
         step();
      end
   endtask

   // Memory write cycle: bank register update, RAM write, or nothing.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int delay);
      logic [3:0] hits;
      logic       access;
      hits    = model_hits(a);
      access  = in_window(a) && !WRITE_PROTECT && (hits == 4'b0000);
      ADDR    = a; DIN = d;
      SLTSL_n = 1'b0; MERQ_n = 1'b0; WR_n = 1'b0;
      step();
      for (int i = 0; i < 4; i++)
         if (hits[i]) m_bank[i] = d & ~BANK_REG_MASK;
      if (access) begin
         exp_req = 1'b1; exp_we = 1'b1; exp_addr = model_addr(a); exp_wdata = d;
         exp_wait_n = 1'b0;
         repeat (delay) step();
         RAM_ACK = 1'b1;
         step();
         RAM_ACK = 1'b0;
         exp_req = 1'b0; exp_wait_n = 1'b1;
         step();
         release_bus();
         step();
      end else begin
         step();
         release_bus();
         step();
      end
   endtask

   initial begin
      RESET = 1'b1; BUS_RESET_n = 1'b1;
      release_bus();
      ADDR = 16'h0000; DIN = 8'h00;
      BANK_REG_ADDR0 = 16'h5000; BANK_REG_ADDR1 = 16'h7000;
      BANK_REG_ADDR2 = 16'h9000; BANK_REG_ADDR3 = 16'hB000;
      BANK_REG_ADDR_MASK = 16'h07FF; BANK_REG_MASK = 8'hC0;
      BANK_REG_INIT0 = 8'h00; BANK_REG_INIT1 = 8'h01;
      BANK_REG_INIT2 = 8'h02; BANK_REG_INIT3 = 8'h03;
      WRITE_PROTECT = 1'b0; IS_16K_BANK = 1'b0; CS1_MASK = 1'b0; CS2_MASK = 1'b0;
      MEMORY_TOP_ADDR = 24'h100000;
      RAM_ACK = 1'b0; RAM_RDATA = 8'h00;
      model_reset();
      step();
      chk_en = 1'b1;
      step();
      RESET = 1'b0;
      step();
      #3;
      check("reset_RAM_ADDR", RAM_ADDR, 24'h000000);
      check("reset_RAM_WE", RAM_WE, 1'b0);
      check("reset_RAM_WDATA", RAM_WDATA, 8'h00);
      step();

      // 8K mode read through bank1.
      bus_read(16'h6123, 8'hA5, 2, 1'b1, 24'h102123);
      // Masked bank write: bank2 <= FFh & ~C0h, no RAM access.
      bus_write(16'h97FF, 8'hFF, 0);
      bus_read(16'h8000, 8'h3C, 0, 1'b1, 24'h17E000);
      // RAM write with no bank match, then the same under write protect.
      bus_write(16'h4010, 8'h5A, 1);
      WRITE_PROTECT = 1'b1;
      bus_write(16'h4010, 8'h5A, 0);
      WRITE_PROTECT = 1'b0;
      // Chip-select masks and out-of-window addresses.
      CS2_MASK = 1'b1;
      bus_read(16'h8000, 8'h11, 0, 1'b0, 24'h0);
      CS2_MASK = 1'b0;
      CS1_MASK = 1'b1;
      bus_read(16'h4000, 8'h22, 0, 1'b0, 24'h0);
      CS1_MASK = 1'b0;
      bus_read(16'h3FFF, 8'h33, 0, 1'b0, 24'h0);
      bus_read(16'hC000, 8'h44, 0, 1'b0, 24'h0);

      // 16K mode: bank1 = 05h, top of page 2.
      IS_16K_BANK = 1'b1;
      bus_write(16'h7000, 8'h05, 0);
      bus_read(16'hBFFF, 8'h77, 1, 1'b1, 24'h117FFF);
      bus_read(16'h4000, 8'h78, 0, 1'b1, 24'h100000);
      IS_16K_BANK = 1'b0;

      // Address wrap past 2^24.
      MEMORY_TOP_ADDR = 24'hFF0000;
      BANK_REG_MASK = 8'h00;
      bus_write(16'hB000, 8'hFF, 0);
      bus_read(16'hBFFF, 8'h99, 0, 1'b1, 24'h1EFFFF);

      // Every bank register matches a single write.
      MEMORY_TOP_ADDR = 24'h100000;
      BANK_REG_MASK = 8'hC0;
      BANK_REG_ADDR_MASK = 16'hFFFF;
      bus_write(16'h4000, 8'h81, 0);
      BANK_REG_ADDR_MASK = 16'h07FF;
      bus_read(16'hA000, 8'hB1, 0, 1'b1, 24'h102000);
      bus_read(16'h4000, 8'hB2, 0, 1'b1, 24'h102000);

      // Bus reset in REQ abandons the request; a late ACK is ignored.
      ADDR = 16'hA000;
      SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
      step();
      exp_req = 1'b1; exp_we = 1'b0; exp_addr = model_addr(16'hA000); exp_wait_n = 1'b0;
      step();
      BUS_RESET_n = 1'b0;
      release_bus();
      step();
      model_reset();
      #3 check("busreset_RAM_REQ", RAM_REQ, 1'b0);
      BUS_RESET_n = 1'b1;
      RAM_ACK = 1'b1; RAM_RDATA = 8'hEE;
      step();
      RAM_ACK = 1'b0; RAM_RDATA = 8'h00;
      step();
      #3 check("late_ack_DOUT", DOUT, 8'h00);
      step();
      // Banks back at init values.
      bus_read(16'hA000, 8'hC3, 0, 1'b1, 24'h106000);
      bus_read(16'h4000, 8'hC4, 0, 1'b1, 24'h100000);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/megarom_bank_mapper.md
Name: megarom_bank_mapper

Overview:
- Megarom mapper stage directly downstream of the megarom configuration registers.
- Consumes the configuration (bank-register addresses and masks, init values, bank size, write protect, CS masks, memory top address) and holds the four live bank registers.
- Decodes MSX slot cycles in 4000h-BFFFh into RAM read/write requests through a req/ack handshake.
- Returns read data to the bus, holding the Z80 with WAIT_n until the RAM answers.

Parameters:
RAM_ADDR_WIDTH, 24, width of RAM_ADDR and MEMORY_TOP_ADDR (byte address)
BANK_WIDTH, 8, width of each bank register

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous active-high reset
BUS_RESET_n  in  1  MSX bus reset, sampled on CLK; low acts like RESET for bank registers and FSM
SLTSL_n, MERQ_n, RD_n, WR_n  in  1 each  MSX bus strobes
ADDR  in  16  bus address
DIN  in  8  bus write data
DOUT  out  8  bus read data
BUSDIR_n  out  1  low while driving DOUT
WAIT_n  out  1  bus wait request
BANK_REG_ADDR0..3  in  16 each  bank register write address
BANK_REG_ADDR_MASK  in  16  address compare don't-care bits (1 = ignore bit)
BANK_REG_MASK  in  8  data bits forced to 0 on bank write (1 = clear)
BANK_REG_INIT0..3  in  BANK_WIDTH each  bank values loaded at reset
WRITE_PROTECT, IS_16K_BANK, CS1_MASK, CS2_MASK  in  1 each  configuration flags
MEMORY_TOP_ADDR  in  RAM_ADDR_WIDTH  RAM base of the ROM image
RAM_REQ  out  1  request, held until RAM_ACK
RAM_WE  out  1  1 = write
RAM_ADDR  out  RAM_ADDR_WIDTH  byte address
RAM_WDATA  out  8  write data
RAM_ACK  in  1  one-cycle completion pulse
RAM_RDATA  in  8  valid with RAM_ACK

Behaviour:

Clocking and reset
- One clock, CLK. Reset RESET is synchronous and active-high.
- On RESET or !BUS_RESET_n:
  - bank[i] <= BANK_REG_INITi.
  - FSM -> IDLE.
  - RAM_REQ=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0.
  - DOUT=0, BUSDIR_n=1, WAIT_n=1.
  - prev_rd_n=prev_wr_n=1.
- Reset mid-transaction abandons the request; a late RAM_ACK in IDLE is ignored.

Cycle detection
- rd_n = SLTSL_n|MERQ_n|RD_n; wr_n = SLTSL_n|MERQ_n|WR_n.
- Registered previous values give falling-edge pulses det_rd and det_wr. Only edges start work.

Decode
- cs1 = ADDR in 4000h-7FFFh and !CS1_MASK.
- cs2 = ADDR in 8000h-BFFFh and !CS2_MASK.
- Bank index:
  - 8K mode: {ADDR[15],ADDR[13]}, giving 0..3 for 4000/6000/8000/A000h.
  - 16K mode: {1'b0,ADDR[15]}, giving bank0 at 4000h and bank1 at 8000h.
- Offset:
  - 8K: {bank[idx],ADDR[12:0]}.
  - 16K: {bank[idx],ADDR[13:0]}.
  - Zero-extended or truncated to RAM_ADDR_WIDTH.
- RAM_ADDR = MEMORY_TOP_ADDR + offset, modulo 2^RAM_ADDR_WIDTH (wrap, no saturation).

Bank register write
- On det_wr, for every i with ((ADDR^BANK_REG_ADDRi) & ~BANK_REG_ADDR_MASK)==0: bank[i] <= DIN & ~BANK_REG_MASK.
- Several matches all update in the same cycle.
- Independent of CS masks and WRITE_PROTECT. Takes effect for the next decoded cycle.

FSM: IDLE, REQ, DONE
- IDLE -> REQ, on det_rd & (cs1|cs2):
  - latch RAM_ADDR; RAM_WE=0; RAM_REQ=1; WAIT_n=0 in the same cycle.
- IDLE -> REQ, on det_wr & (cs1|cs2) & !WRITE_PROTECT & no bank match:
  - RAM_WE=1; RAM_WDATA=DIN; RAM_REQ=1; WAIT_n=0.
- Write hitting a bank register or under WRITE_PROTECT: no RAM access; stays in IDLE.
- REQ:
  - hold RAM_REQ/RAM_ADDR/RAM_WE/RAM_WDATA stable until RAM_ACK.
  - On RAM_ACK: RAM_REQ=0, WAIT_n=1; if read, DOUT<=RAM_RDATA and BUSDIR_n<=0. Go to DONE.
  - ACK in the same cycle as the request is impossible (REQ is registered); minimum latency is request+1.
- DONE:
  - hold DOUT/BUSDIR_n while rd_n=0.
  - When both rd_n and wr_n are 1: BUSDIR_n=1, DOUT=0, go to IDLE.
- Bus strobe released while in REQ: the RAM transaction still completes; DOUT is not driven if rd_n=1 at ACK.
- Edges arriving outside IDLE are ignored.

Other rules
- BUSDIR_n is never low outside DONE with rd_n=0.

Test Plan:
- RESET with INIT0..3=00,01,02,03, 8K mode, MEMORY_TOP_ADDR=100000h; read 6123h -> RAM_ADDR=102123h, WAIT_n low until ACK, DOUT=RAM_RDATA, BUSDIR_n=0 until RD_n high.
- BANK_REG_ADDR2=9000h, mask ADDR=07FFh, BANK_REG_MASK=C0h; write FFh to 97FFh -> bank2=3Fh, no RAM_REQ; next read 8000h -> RAM_ADDR=TOP+7E000h.
- 16K mode, bank1=05h; read BFFFh -> offset 17FFFh.
- WRITE_PROTECT=0, write 5Ah to 4010h (no bank match) -> RAM_REQ, RAM_WE=1, RAM_WDATA=5Ah; with WRITE_PROTECT=1 -> no request.
- CS2_MASK=1; read 8000h -> no RAM_REQ, BUSDIR_n=1, WAIT_n=1.
- Assert BUS_RESET_n low while in REQ -> RAM_REQ=0, WAIT_n=1 next cycle, banks back to INIT; late RAM_ACK is ignored.
